// File: rtl/spi_accel_responder.sv
// SPI mode-3 responder that stands in for the 3-axis accelerometer's register interface.
// All SPI pins are oversampled in the clk domain; SCLK must be >= 8x slower than clk.
module spi_accel_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  input  logic [15:0] data_x,
  input  logic [15:0] data_y,
  input  logic [15:0] data_z,
  input  logic        sample_valid,
  output logic        int1,
  output logic [7:0]  power_ctl,
  output logic [7:0]  data_format,
  output logic [7:0]  bw_rate,
  output logic        reg_wr,
  output logic [5:0]  reg_wr_addr
);

  localparam logic [5:0] AddrDevid     = 6'h00;
  localparam logic [5:0] AddrBwRate    = 6'h2C;
  localparam logic [5:0] AddrPowerCtl  = 6'h2D;
  localparam logic [5:0] AddrIntEnable = 6'h2E;
  localparam logic [5:0] AddrIntSource = 6'h30;
  localparam logic [5:0] AddrDataFmt   = 6'h31;
  localparam logic [5:0] AddrDataX0    = 6'h32;
  localparam logic [5:0] AddrDataZ1    = 6'h37;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  // Synchronizer and edge-history flops
  logic cs_s1_q, cs_s2_q, cs_prev_q;
  logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic sdi_s1_q, sdi_s2_q;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        mb_q, mb_d;
  logic [5:0]  addr_q, addr_d;
  logic        sdo_q, sdo_d;
  logic        sdo_oe_q, sdo_oe_d;
  logic [7:0]  bw_rate_q, bw_rate_d;
  logic [7:0]  power_ctl_q, power_ctl_d;
  logic [7:0]  int_enable_q, int_enable_d;
  logic [7:0]  data_format_q, data_format_d;
  logic        data_ready_q, data_ready_d;
  logic        int1_q, int1_d;
  logic        reg_wr_q, reg_wr_d;
  logic [5:0]  reg_wr_addr_q, reg_wr_addr_d;
  logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [15:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_z_q, sh_z_d;

  logic       sclk_rise, sclk_fall, cs_fall;
  logic [7:0] rx_byte;
  logic [5:0] next_addr;
  logic [5:0] rd_addr;
  logic [7:0] rd_byte;
  logic       dr_clr;

  assign sclk_rise = ~sclk_prev_q & sclk_s2_q;
  assign sclk_fall = sclk_prev_q & ~sclk_s2_q;
  assign cs_fall   = cs_prev_q & ~cs_s2_q;
  assign rx_byte   = {rx_q[6:0], sdi_s2_q};
  // MB wraps naturally at 0x3F -> 0x00 through the 6-bit add.
  assign next_addr = mb_q ? addr_q + 6'd1 : addr_q;
  // At end of CMD the address is still in the shift register; later bytes use the advanced one.
  assign rd_addr   = (state_q == StCmd) ? rx_byte[5:0] : next_addr;

  // Two-stage synchronizers for the asynchronous SPI pins, plus history for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_s1_q   <= 1'b1;
      sclk_s2_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      sdi_s1_q    <= 1'b0;
      sdi_s2_q    <= 1'b0;
    end else begin
      cs_s1_q     <= spi_cs_n;
      cs_s2_q     <= cs_s1_q;
      cs_prev_q   <= cs_s2_q;
      sclk_s1_q   <= spi_sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sdi_s1_q    <= spi_sdi;
      sdi_s2_q    <= sdi_s1_q;
    end
  end

  // Register-map read mux
  always_comb begin
    rd_byte = 8'h00;
    case (rd_addr)
      AddrDevid:     rd_byte = DEVID;
      AddrBwRate:    rd_byte = bw_rate_q;
      AddrPowerCtl:  rd_byte = power_ctl_q;
      AddrIntEnable: rd_byte = int_enable_q;
      AddrIntSource: rd_byte = {data_ready_q, 7'b0};
      AddrDataFmt:   rd_byte = data_format_q;
      6'h32:         rd_byte = sh_x_q[7:0];
      6'h33:         rd_byte = sh_x_q[15:8];
      6'h34:         rd_byte = sh_y_q[7:0];
      6'h35:         rd_byte = sh_y_q[15:8];
      6'h36:         rd_byte = sh_z_q[7:0];
      6'h37:         rd_byte = sh_z_q[15:8];
      default:       rd_byte = 8'h00;
    endcase
  end

  // Transaction FSM, register writes, sample capture and interrupt next-state
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    rw_d          = rw_q;
    mb_d          = mb_q;
    addr_d        = addr_q;
    sdo_d         = sdo_q;
    sdo_oe_d      = ~cs_s2_q;
    bw_rate_d     = bw_rate_q;
    power_ctl_d   = power_ctl_q;
    int_enable_d  = int_enable_q;
    data_format_d = data_format_q;
    reg_wr_d      = 1'b0;
    reg_wr_addr_d = reg_wr_addr_q;
    x_d           = x_q;
    y_d           = y_q;
    z_d           = z_q;
    sh_x_d        = sh_x_q;
    sh_y_d        = sh_y_q;
    sh_z_d        = sh_z_q;
    dr_clr        = 1'b0;

    if (sample_valid) begin
      x_d = data_x;
      y_d = data_y;
      z_d = data_z;
    end

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = 3'd0;
        if (cs_fall) begin
          state_d = StCmd;
          rx_d    = 8'h00;
          tx_d    = 8'h00;
          // Snapshot so a multi-byte sample read is coherent
          sh_x_d  = x_q;
          sh_y_d  = y_q;
          sh_z_d  = z_q;
        end
      end
      StCmd, StData: begin
        if (cs_s2_q) begin
          // Partial byte is simply dropped
          state_d = StIdle;
        end else if (sclk_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == StCmd) begin
              rw_d    = rx_byte[7];
              mb_d    = rx_byte[6];
              addr_d  = rx_byte[5:0];
              state_d = StData;
              tx_d    = rx_byte[7] ? rd_byte : 8'h00;
              dr_clr  = rx_byte[7] && (rx_byte[5:0] >= AddrDataX0) &&
                        (rx_byte[5:0] <= AddrDataZ1);
            end else begin
              if (!rw_q) begin
                reg_wr_d      = 1'b1;
                reg_wr_addr_d = addr_q;
                case (addr_q)
                  AddrBwRate:    bw_rate_d     = rx_byte;
                  AddrPowerCtl:  power_ctl_d   = rx_byte;
                  AddrIntEnable: int_enable_d  = rx_byte;
                  AddrDataFmt:   data_format_d = rx_byte;
                  default: ;
                endcase
              end
              addr_d = next_addr;
              tx_d   = rw_q ? rd_byte : 8'h00;
            end
          end
        end else if (sclk_fall) begin
          sdo_d = tx_q[7];
          tx_d  = {tx_q[6:0], 1'b0};
        end
      end
      default: state_d = StIdle;
    endcase

    // A new sample beats a same-cycle clear
    data_ready_d = sample_valid | (data_ready_q & ~dr_clr);
    int1_d       = data_ready_q & int_enable_q[7];
  end

  // State and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      bit_cnt_q     <= 3'd0;
      rx_q          <= 8'h00;
      tx_q          <= 8'h00;
      rw_q          <= 1'b0;
      mb_q          <= 1'b0;
      addr_q        <= 6'd0;
      sdo_q         <= 1'b0;
      sdo_oe_q      <= 1'b0;
      bw_rate_q     <= BW_RATE_RST;
      power_ctl_q   <= 8'h00;
      int_enable_q  <= 8'h00;
      data_format_q <= 8'h00;
      data_ready_q  <= 1'b0;
      int1_q        <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_wr_addr_q <= 6'd0;
      x_q           <= 16'h0000;
      y_q           <= 16'h0000;
      z_q           <= 16'h0000;
      sh_x_q        <= 16'h0000;
      sh_y_q        <= 16'h0000;
      sh_z_q        <= 16'h0000;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      rw_q          <= rw_d;
      mb_q          <= mb_d;
      addr_q        <= addr_d;
      sdo_q         <= sdo_d;
      sdo_oe_q      <= sdo_oe_d;
      bw_rate_q     <= bw_rate_d;
      power_ctl_q   <= power_ctl_d;
      int_enable_q  <= int_enable_d;
      data_format_q <= data_format_d;
      data_ready_q  <= data_ready_d;
      int1_q        <= int1_d;
      reg_wr_q      <= reg_wr_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      x_q           <= x_d;
      y_q           <= y_d;
      z_q           <= z_d;
      sh_x_q        <= sh_x_d;
      sh_y_q        <= sh_y_d;
      sh_z_q        <= sh_z_d;
    end
  end

  assign spi_sdo     = sdo_q;
  assign spi_sdo_oe  = sdo_oe_q;
  assign int1        = int1_q;
  assign power_ctl   = power_ctl_q;
  assign data_format = data_format_q;
  assign bw_rate     = bw_rate_q;
  assign reg_wr      = reg_wr_q;
  assign reg_wr_addr = reg_wr_addr_q;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Bench for spi_accel_responder: SPI mode-3 master, register-map model, scoreboard monitors.
module tb_spi_accel_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_sclk = 1'b1;
  logic        spi_sdi = 1'b0;
  logic        spi_sdo, spi_sdo_oe;
  logic [15:0] data_x = '0, data_y = '0, data_z = '0;
  logic        sample_valid = 1'b0;
  logic        int1;
  logic [7:0]  power_ctl, data_format, bw_rate;
  logic        reg_wr;
  logic [5:0]  reg_wr_addr;

  always #5 clk = ~clk;

  spi_accel_responder dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_sdi     (spi_sdi),
    .spi_sdo     (spi_sdo),
    .spi_sdo_oe  (spi_sdo_oe),
    .data_x      (data_x),
    .data_y      (data_y),
    .data_z      (data_z),
    .sample_valid(sample_valid),
    .int1        (int1),
    .power_ctl   (power_ctl),
    .data_format (data_format),
    .bw_rate     (bw_rate),
    .reg_wr      (reg_wr),
    .reg_wr_addr (reg_wr_addr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_reg [64];   // writable registers, indexed by address
  logic        m_dr;
  logic [15:0] m_live [3];
  logic [15:0] m_shadow [3];
  logic [7:0]  rd_exp [$];
  logic [13:0] wr_exp [$];   // {addr, data}
  logic [7:0]  wbuf [8];

  function automatic bit is_writable(input logic [5:0] a);
    return (a == 6'h2C) || (a == 6'h2D) || (a == 6'h2E) || (a == 6'h31);
  endfunction

  function automatic logic [7:0] model_read(input logic [5:0] a);
    int k;
    if (a == 6'h00) return 8'hE5;
    if (a == 6'h30) return {m_dr, 7'd0};
    if (is_writable(a)) return m_reg[a];
    if (a >= 6'h32 && a <= 6'h37) begin
      k = int'(a) - 50;
      return (k % 2 == 1) ? m_shadow[k / 2][15:8] : m_shadow[k / 2][7:0];
    end
    return 8'h00;
  endfunction

  task automatic sample_pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    data_x = x;
    data_y = y;
    data_z = z;
    sample_valid = 1'b1;
    m_live[0] = x;
    m_live[1] = y;
    m_live[2] = z;
    m_dr = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int b = 7; b > 7 - n; b--) begin
      spi_sclk = 1'b0;
      spi_sdi  = v[b];
      repeat (6) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  // One CS-framed transaction: command, nbytes full data bytes from wbuf, then cut extra bits.
  task automatic spi_txn(input logic [7:0] cmd, input int nbytes, input int cut);
    logic [5:0] a;
    a = cmd[5:0];
    for (int k = 0; k < 3; k++) m_shadow[k] = m_live[k];
    if (cmd[7]) begin
      if (a >= 6'h32 && a <= 6'h37) m_dr = 1'b0;
      for (int i = 0; i < nbytes; i++) begin
        rd_exp.push_back(model_read(a));
        if (cmd[6]) a = a + 6'd1;
      end
    end else begin
      for (int i = 0; i < nbytes; i++) begin
        wr_exp.push_back({a, wbuf[i]});
        if (is_writable(a)) m_reg[a] = wbuf[i];
        if (cmd[6]) a = a + 6'd1;
      end
    end
    @(negedge clk);
    spi_cs_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("oe_still_low_2clk", {31'd0, spi_sdo_oe}, 32'd0);
    @(negedge clk);
    chk("oe_high_3clk", {31'd0, spi_sdo_oe}, 32'd1);
    repeat (3) @(negedge clk);
    send_bits(cmd, 8);
    for (int i = 0; i < nbytes; i++) send_bits(wbuf[i], 8);
    if (cut > 0) send_bits(wbuf[nbytes], cut);
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("oe_low_after_cs", {31'd0, spi_sdo_oe}, 32'd0);
  endtask

  task automatic post_chk();
    chk("power_ctl", {24'd0, power_ctl}, {24'd0, m_reg[6'h2D]});
    chk("data_format", {24'd0, data_format}, {24'd0, m_reg[6'h31]});
    chk("bw_rate", {24'd0, bw_rate}, {24'd0, m_reg[6'h2C]});
    chk("int1", {31'd0, int1}, {31'd0, m_dr & m_reg[6'h2E][7]});
  endtask

  // ---------------- monitors ----------------
  int         mon_bits;
  int         mon_byte;
  logic [7:0] mon_mosi, mon_miso, mon_cmd, mon_exp;
  logic [13:0] wr_e;

  always @(negedge spi_cs_n) begin
    mon_bits = 0;
    mon_byte = 0;
  end

  // MISO scoreboard: the master samples on SCLK rising edges
  always @(posedge spi_sclk) begin
    if (spi_cs_n === 1'b0) begin
      mon_mosi = {mon_mosi[6:0], spi_sdi};
      mon_miso = {mon_miso[6:0], spi_sdo};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (mon_byte == 0) begin
          mon_cmd = mon_mosi;
        end else if (mon_cmd[7]) begin
          if (rd_exp.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL miso_unexpected: got 0x%0h, expected no read byte", mon_miso);
          end else begin
            mon_exp = rd_exp.pop_front();
            chk("miso_byte", {24'd0, mon_miso}, {24'd0, mon_exp});
          end
        end
        mon_byte++;
      end
    end
  end

  // Write-pulse scoreboard
  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      if (wr_exp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL reg_wr_unexpected: got pulse at addr 0x%0h, expected none", reg_wr_addr);
      end else begin
        wr_e = wr_exp.pop_front();
        chk("reg_wr_addr", {26'd0, reg_wr_addr}, {26'd0, wr_e[13:8]});
        case (wr_e[13:8])
          6'h2C: chk("wr_bw_rate", {24'd0, bw_rate}, {24'd0, wr_e[7:0]});
          6'h2D: chk("wr_power_ctl", {24'd0, power_ctl}, {24'd0, wr_e[7:0]});
          6'h31: chk("wr_data_format", {24'd0, data_format}, {24'd0, wr_e[7:0]});
          default: ;
        endcase
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] cmd;
    logic [5:0] a;
    int         nb, cut;
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_reg[6'h2C] = 8'h0A;
    m_dr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_live[k]   = 16'h0;
      m_shadow[k] = 16'h0;
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sdo", {31'd0, spi_sdo}, 32'd0);
    chk("rst_sdo_oe", {31'd0, spi_sdo_oe}, 32'd0);
    chk("rst_int1", {31'd0, int1}, 32'd0);
    chk("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
    chk("rst_reg_wr_addr", {26'd0, reg_wr_addr}, 32'd0);
    chk("rst_power_ctl", {24'd0, power_ctl}, 32'd0);
    chk("rst_data_format", {24'd0, data_format}, 32'd0);
    chk("rst_bw_rate", {24'd0, bw_rate}, 32'h0A);

    // DEVID read
    spi_txn(8'h80, 1, 0);
    post_chk();

    // Write POWER_CTL then read it back
    wbuf[0] = 8'h08;
    spi_txn(8'h2D, 1, 0);
    chk("power_ctl_08", {24'd0, power_ctl}, 32'h08);
    spi_txn(8'hAD, 1, 0);
    post_chk();

    // Coherent multi-byte sample read
    sample_pulse(16'hFF38, 16'h0064, 16'h0100);
    spi_txn(8'hF2, 6, 0);
    post_chk();

    // New sample mid-read leaves the snapshot intact
    fork
      spi_txn(8'hF2, 6, 0);
      begin
        repeat (20) @(posedge spi_sclk);
        sample_pulse(16'h1234, 16'h8001, 16'h7FFE);
      end
    join
    spi_txn(8'hF2, 6, 0);
    post_chk();

    // Data-ready interrupt
    wbuf[0] = 8'h80;
    spi_txn(8'h2E, 1, 0);
    post_chk();
    sample_pulse(16'h0001, 16'h0002, 16'h0003);
    chk("int1_1clk", {31'd0, int1}, 32'd0);
    @(negedge clk);
    chk("int1_2clk", {31'd0, int1}, 32'd1);
    spi_txn(8'hB2, 1, 0);
    chk("int1_cleared", {31'd0, int1}, 32'd0);
    post_chk();
    sample_pulse(16'h0A0B, 16'h0C0D, 16'h0E0F);
    // Sample lands in the very cycle the command's clear takes effect
    fork
      spi_txn(8'hB2, 1, 0);
      begin
        repeat (8) @(posedge spi_sclk);
        @(negedge clk);
        sample_pulse(16'h1111, 16'h2222, 16'h3333);
      end
    join
    chk("int1_set_wins", {31'd0, int1}, 32'd1);
    post_chk();

    // Aborted write after 5 bits, then wrap-around MB read
    wbuf[0] = 8'h5A;
    spi_txn(8'h31, 0, 5);
    chk("data_format_kept", {24'd0, data_format}, 32'h00);
    spi_txn(8'hFF, 2, 0);
    post_chk();

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0: a = 6'h00;
        1: a = 6'h2C;
        2: a = 6'h2D;
        3: a = 6'h2E;
        4: a = 6'h30;
        5: a = 6'h31;
        6: a = 6'h32 + 6'($urandom_range(0, 5));
        7: a = 6'h3E;
        8: a = 6'h3F;
        default: a = 6'($urandom_range(0, 63));
      endcase
      cmd = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a};
      nb  = $urandom_range(0, 4);
      cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
      if ($urandom_range(0, 2) == 0)
        sample_pulse(16'($urandom), 16'($urandom), 16'($urandom));
      spi_txn(cmd, nb, cut);
      post_chk();
    end

    repeat (10) @(negedge clk);
    chk("rd_exp_drained", rd_exp.size(), 32'd0);
    chk("wr_exp_drained", wr_exp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
